// File: rtl/lab3_mem_line_responder_pkg.sv
// ============================================================================
// Module      : lab3_mem_line_responder_pkg
// Description : 16B line memory message types, type_ encodings and helpers
//               for the lab3 memory line responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lab3_mem_line_responder_pkg;

    // Field widths of the 16B line messages
    localparam int unsigned MEM_TYPE_W   = 3;
    localparam int unsigned MEM_OPAQUE_W = 8;
    localparam int unsigned MEM_ADDR_W   = 32;
    localparam int unsigned MEM_LEN_W    = 4;
    localparam int unsigned MEM_TEST_W   = 2;
    localparam int unsigned MEM_DATA_W   = 128;

    // type_ encodings shared by requests and responses
    localparam logic [MEM_TYPE_W-1:0] MEM_MSG_TYPE_READ  = 3'd0;
    localparam logic [MEM_TYPE_W-1:0] MEM_MSG_TYPE_WRITE = 3'd1;
    localparam logic [MEM_TYPE_W-1:0] MEM_MSG_TYPE_INIT  = 3'd2;

    // Seed loaded into the delay LFSR on reset
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   type_;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   type_;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_TEST_W-1:0]   test;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_resp_16B_t;

    // WRITE and INIT modify the store; every other type behaves as a read
    function automatic logic is_store_type(input logic [MEM_TYPE_W-1:0] t);
        return (t == MEM_MSG_TYPE_WRITE) || (t == MEM_MSG_TYPE_INIT);
    endfunction

    // 8-bit Fibonacci LFSR step, taps 8,6,5,4
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lab3_mem_line_responder_store.sv
// ============================================================================
// Module      : lab3_mem_LineResponderStore
// Description : p_num_lines x 128b line array, one combinational read port
//               and one synchronous write port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab3_mem_LineResponderStore
    import lab3_mem_line_responder_pkg::*;
#(
    parameter int unsigned p_num_lines = 256
) (
    input  logic                           clk,
    input  logic [$clog2(p_num_lines)-1:0] i_rd_idx,
    output logic [MEM_DATA_W-1:0]          o_rd_data,
    input  logic                           i_wr_en,
    input  logic [$clog2(p_num_lines)-1:0] i_wr_idx,
    input  logic [MEM_DATA_W-1:0]          i_wr_data
);

    logic [MEM_DATA_W-1:0] mem_q [p_num_lines];

    // Asynchronous read so the responder can latch the line at accept
    assign o_rd_data = mem_q[i_rd_idx];

    // Write commits on the accept edge; no reset on the array
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_idx] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lab3_mem_line_responder.sv
// ============================================================================
// Module      : lab3_mem_line_responder
// Description : Blocking memory-side responder for the 16B line protocol.
//               Accepts one request at a time, reads/writes a full line in
//               the internal store at accept, and answers after
//               1+p_latency cycles.
//               Optional macro LAB3_MEM_LINE_RESPONDER_RAND_DELAY_EN adds a
//               0..3 cycle LFSR-driven delay to every transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab3_mem_line_responder
    import lab3_mem_line_responder_pkg::*;
#(
    parameter int unsigned p_num_lines = 256,
    parameter int unsigned p_latency   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  memreq_msg,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    output mem_resp_16B_t memresp_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy
);

    localparam int unsigned IDX_W = $clog2(p_num_lines);
    // Holds p_latency (<=15) plus the optional random delay (<=3)
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_WAIT = 2'd1,
        STATE_RESP = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [MEM_TYPE_W-1:0]   type_q,   type_d;
    logic [MEM_OPAQUE_W-1:0] opaque_q, opaque_d;
    logic [MEM_DATA_W-1:0]   data_q,   data_d;
    logic [CNT_W-1:0]        count_q,  count_d;

    logic [IDX_W-1:0]        w_idx;
    logic [MEM_DATA_W-1:0]   w_rd_data;
    logic                    w_is_store;
    logic                    w_req_fire;
    logic                    w_store_wen;
    logic [CNT_W-1:0]        w_extra_delay;
    logic [CNT_W-1:0]        w_wait_count;
    logic                    w_unused;

    // Upper address bits, offset bits and len are intentionally ignored
    assign w_unused = &{1'b0, memreq_msg};

    assign w_idx       = memreq_msg.addr[IDX_W+3:4];
    assign w_is_store  = is_store_type(memreq_msg.type_);
    // Ready only from IDLE state and never while reset is held
    assign memreq_rdy  = (state_q == STATE_IDLE) && !reset;
    assign memresp_val = (state_q == STATE_RESP);
    assign w_req_fire  = memreq_val && memreq_rdy;
    assign w_store_wen = w_req_fire && w_is_store;

`ifdef LAB3_MEM_LINE_RESPONDER_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // LFSR advances once per accepted request
    always_comb begin
        lfsr_d = lfsr_q;
        if (w_req_fire) begin
            lfsr_d = lfsr8_next(lfsr_q);
        end
    end

    // LFSR state register, reseeded on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_extra_delay = CNT_W'(lfsr_q[1:0]);
`else
    assign w_extra_delay = '0;
`endif

    assign w_wait_count = CNT_W'(p_latency) + w_extra_delay;

    lab3_mem_LineResponderStore #(
        .p_num_lines (p_num_lines)
    ) u_store (
        .clk       (clk),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_store_wen),
        .i_wr_idx  (w_idx),
        .i_wr_data (memreq_msg.data)
    );

    // Next-state and latched-field logic of the transaction FSM
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        opaque_d = opaque_q;
        data_d   = data_q;
        count_d  = count_q;
        case (state_q)
            STATE_IDLE: begin
                if (w_req_fire) begin
                    type_d   = memreq_msg.type_;
                    opaque_d = memreq_msg.opaque;
                    // Stores answer with zero data; reads return the line
                    data_d   = w_is_store ? '0 : w_rd_data;
                    count_d  = w_wait_count;
                    state_d  = (w_wait_count != '0) ? STATE_WAIT : STATE_RESP;
                end
            end
            STATE_WAIT: begin
                count_d = count_q - CNT_W'(1);
                if (count_q <= CNT_W'(1)) begin
                    state_d = STATE_RESP;
                end
            end
            STATE_RESP: begin
                if (memresp_rdy) begin
                    state_d = STATE_IDLE;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // FSM and latched-field registers; reset aborts any transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= STATE_IDLE;
            type_q   <= '0;
            opaque_q <= '0;
            data_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            opaque_q <= opaque_d;
            data_q   <= data_d;
            count_q  <= count_d;
        end
    end

    // Response is built purely from registered fields, stable under stall
    always_comb begin
        memresp_msg        = '0;
        memresp_msg.type_  = type_q;
        memresp_msg.opaque = opaque_q;
        memresp_msg.test   = '0;
        memresp_msg.len    = '0;
        memresp_msg.data   = data_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_lab3_mem_line_responder.sv
// ============================================================================
// Module      : tb_lab3_mem_line_responder
// Description : Directed self-checking bench. Instance 0 has 16 lines and
//               p_latency=0, instance 1 has 256 lines and p_latency=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lab3_mem_line_responder;
    import lab3_mem_line_responder_pkg::*;

`ifdef LAB3_MEM_LINE_RESPONDER_RAND_DELAY_EN
    localparam int RMAX = 3;
`else
    localparam int RMAX = 0;
`endif

    localparam logic [127:0] C_D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] C_DA = 128'hAAAA5555DEADBEEF0000111122223333;
    localparam logic [127:0] C_DB = 128'hB0B0B0B0CAFEF00D123456789ABCDEF0;

    logic          clk = 1'b0;
    logic          rst         [2];
    mem_req_16B_t  req_msg     [2];
    logic          req_val     [2];
    logic          req_rdy     [2];
    mem_resp_16B_t resp_msg    [2];
    logic          resp_val    [2];
    logic          resp_rdy    [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            lab3_mem_line_responder #(
                .p_num_lines ((g == 0) ? 16 : 256),
                .p_latency   ((g == 0) ? 0 : 3)
            ) u_dut (
                .clk         (clk),
                .reset       (rst[g]),
                .memreq_msg  (req_msg[g]),
                .memreq_val  (req_val[g]),
                .memreq_rdy  (req_rdy[g]),
                .memresp_msg (resp_msg[g]),
                .memresp_val (resp_val[g]),
                .memresp_rdy (resp_rdy[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic lat_ok(input int d, input int lat);
        int lo;
        lo = 1 + ((d == 0) ? 0 : 3);
        return (lat >= lo) && (lat <= lo + RMAX);
    endfunction

    function automatic mem_resp_16B_t exp_resp(input logic [2:0] t, input logic [7:0] op,
                                               input logic [127:0] data);
        mem_resp_16B_t r;
        r        = '0;
        r.type_  = t;
        r.opaque = op;
        r.data   = data;
        return r;
    endfunction

    // One full transaction on instance d; called and returns at a negedge.
    // bp extra stalled cycles follow the first RESP cycle.
    task automatic txn(input int d, input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] addr, input logic [127:0] data, input int bp,
                       output mem_resp_16B_t resp, output int lat);
        int k;
        resp = '0;
        lat  = 0;
        k    = 0;
        while (!req_rdy[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_rdy[d]) begin
            check("req_rdy_timeout", 160'(req_rdy[d]), 160'(1));
            return;
        end
        req_msg[d].type_  = t;
        req_msg[d].opaque = op;
        req_msg[d].addr   = addr;
        req_msg[d].len    = 4'd0;
        req_msg[d].data   = data;
        req_val[d]        = 1'b1;
        resp_rdy[d]       = 1'b0;
        @(negedge clk);
        req_val[d] = 1'b0;
        lat        = 1;
        while (!resp_val[d] && lat < 40) begin
            check("rdy_low_wait", 160'(req_rdy[d]), 160'(0));
            @(negedge clk);
            lat++;
        end
        if (!resp_val[d]) begin
            check("resp_timeout", 160'(resp_val[d]), 160'(1));
            return;
        end
        check("rdy_low_resp", 160'(req_rdy[d]), 160'(0));
        resp = resp_msg[d];
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_val", 160'(resp_val[d]), 160'(1));
            check("bp_msg", 160'(resp_msg[d]), 160'(resp));
            check("bp_rdy", 160'(req_rdy[d]), 160'(0));
        end
        resp_rdy[d] = 1'b1;
        @(negedge clk);
        resp_rdy[d] = 1'b0;
        check("rdy_after_fire", 160'(req_rdy[d]), 160'(1));
        check("val_after_fire", 160'(resp_val[d]), 160'(0));
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_resp_16B_t r;
        int            lat;

        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            req_val[d]  = 1'b0;
            resp_rdy[d] = 1'b0;
            req_msg[d]  = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            check("rst_req_rdy", 160'(req_rdy[d]), 160'(0));
            check("rst_resp_val", 160'(resp_val[d]), 160'(0));
            check("rst_resp_msg", 160'(resp_msg[d]), 160'(0));
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("post_rst_rdy", 160'(req_rdy[d]), 160'(1));
        end

        // Latency 0: INIT then READ of the same line
        txn(0, MEM_MSG_TYPE_INIT, 8'h05, 32'h0000_1000, C_D1, 0, r, lat);
        check("l0_init_resp", 160'(r), 160'(exp_resp(MEM_MSG_TYPE_INIT, 8'h05, '0)));
        check("l0_init_lat", 160'(lat_ok(0, lat)), 160'(1));
        txn(0, MEM_MSG_TYPE_READ, 8'h06, 32'h0000_1000, '0, 0, r, lat);
        check("l0_read_resp", 160'(r), 160'(exp_resp(MEM_MSG_TYPE_READ, 8'h06, C_D1)));
        check("l0_read_lat", 160'(lat_ok(0, lat)), 160'(1));

        // Latency 3: read with 5 cycles of response backpressure
        txn(1, MEM_MSG_TYPE_INIT, 8'h11, 32'h0000_1000, C_D1, 0, r, lat);
        check("l3_init_resp", 160'(r), 160'(exp_resp(MEM_MSG_TYPE_INIT, 8'h11, '0)));
        txn(1, MEM_MSG_TYPE_READ, 8'h12, 32'h0000_1000, '0, 4, r, lat);
        check("l3_read_resp", 160'(r), 160'(exp_resp(MEM_MSG_TYPE_READ, 8'h12, C_D1)));
        check("l3_read_lat", 160'(lat_ok(1, lat)), 160'(1));

        // Aliasing on the 16-line instance: 0x10 and 0x110 share line 1
        txn(0, MEM_MSG_TYPE_WRITE, 8'h21, 32'h0000_0010, C_DA, 0, r, lat);
        check("alias_wr_resp", 160'(r), 160'(exp_resp(MEM_MSG_TYPE_WRITE, 8'h21, '0)));
        txn(0, MEM_MSG_TYPE_READ, 8'h22, 32'h0000_0110, '0, 0, r, lat);
        check("alias_rd_resp", 160'(r), 160'(exp_resp(MEM_MSG_TYPE_READ, 8'h22, C_DA)));
        // Unlisted type behaves as a read and echoes its type
        txn(0, 3'd3, 8'h23, 32'h0000_0F1C, '0, 0, r, lat);
        check("other_type_resp", 160'(r), 160'(exp_resp(3'd3, 8'h23, C_DA)));

        // Reset while in WAIT: response dropped, store write kept
        req_msg[1].type_  = MEM_MSG_TYPE_WRITE;
        req_msg[1].opaque = 8'h31;
        req_msg[1].addr   = 32'h0000_0020;
        req_msg[1].len    = 4'd0;
        req_msg[1].data   = C_DB;
        req_val[1]        = 1'b1;
        check("rstw_pre_rdy", 160'(req_rdy[1]), 160'(1));
        @(negedge clk);
        req_val[1] = 1'b0;
        check("rstw_wait_val", 160'(resp_val[1]), 160'(0));
        rst[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rstw_val", 160'(resp_val[1]), 160'(0));
            check("rstw_rdy", 160'(req_rdy[1]), 160'(0));
        end
        rst[1] = 1'b0;
        @(negedge clk);
        check("rstw_rdy_after", 160'(req_rdy[1]), 160'(1));
        repeat (5) begin
            @(negedge clk);
            check("rstw_no_resp", 160'(resp_val[1]), 160'(0));
        end
        txn(1, MEM_MSG_TYPE_READ, 8'h32, 32'h0000_0020, '0, 0, r, lat);
        check("rstw_read_resp", 160'(r), 160'(exp_resp(MEM_MSG_TYPE_READ, 8'h32, C_DB)));

        // Initialise lines 0..7, then 64 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            txn(1, MEM_MSG_TYPE_INIT, 8'(i), 32'(i) << 4, {4{32'hC0DE_0000 + 32'(i)}}, 0, r, lat);
        end
        for (int i = 0; i < 64; i++) begin
            txn(1, MEM_MSG_TYPE_READ, 8'(i), 32'(i % 8) << 4, '0, 0, r, lat);
            check("b2b_resp", 160'(r),
                  160'(exp_resp(MEM_MSG_TYPE_READ, 8'(i), {4{32'hC0DE_0000 + 32'(i % 8)}})));
            check("b2b_lat", 160'(lat_ok(1, lat)), 160'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
